serial_adder_ctrl: RTL and testbench

//   Bit-serial W-bit adder built around one full_adder_1bit cell. Latches two
//   W-bit operands on a start handshake and feeds the cell one bit pair per

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_adder_ctrl_if.sv | 39 +++
 rtl/full_adder_1bit.sv | 16 +
 rtl/serial_adder_ctrl.sv | 143 ++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and width limit.
package serial_add_pkg;

    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Handshake and data bundle for serial_adder_ctrl.
// Optional signed-overflow flag present when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_ctrl_if #(
    parameter int W = 8
);
    import serial_add_pkg::*;

    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_in;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         C_out;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    // Requester side: issues operands, observes result
    modport master (
        output start, A, B, C_in,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  ready, busy, done, S, C_out
    );

    // Adder side: accepts operands, returns result
    modport slave (
        input  start, A, B, C_in,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output ready, busy, done, S, C_out
    );

endinterface

// File: rtl/full_adder_1bit.sv
// Single-bit full adder cell used by the serial adder datapath.
module full_adder_1bit (
    input  logic X,
    input  logic Y,
    input  logic C_in,
    output logic Z,
    output logic C_out
);

    // Sum and carry of one bit pair plus incoming carry
    always_comb begin
        Z     = X ^ Y ^ C_in;
        C_out = (X & Y) | (C_in & (X ^ Y));
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial W-bit adder: latches operands on start, adds one bit pair per
// clock LSB first through a single full_adder_1bit with a registered carry.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder_ctrl #(
    parameter int W = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_ctrl_if.slave bus
);
    import serial_add_pkg::*;

    localparam int CNT_W = $clog2(W + 1);

    state_t           state_q;
    state_t           state_d;
    logic             accept;
    logic             last;

    logic [W-1:0]     a_sr;
    logic [W-1:0]     b_sr;
    logic [W-1:0]     s_sr;
    logic [W-1:0]     s_shift;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [W-1:0]     s_q;
    logic             c_q;

    logic             fa_z;
    logic             fa_c;

    full_adder_1bit u_fa (
        .X     (a_sr[0]),
        .Y     (b_sr[0]),
        .C_in  (carry),
        .Z     (fa_z),
        .C_out (fa_c)
    );

    // Next state, operand-accept strobe and final-bit strobe
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(W - 1)) begin
                    last    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sum register shifted right with the new bit entering at the MSB;
    // written as shift-then-overwrite so it also holds for W=1
    always_comb begin
        s_shift        = s_sr >> 1;
        s_shift[W-1]   = fa_z;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand shift registers, carry loop, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s_q   <= '0;
            c_q   <= 1'b0;
        end else if (accept) begin
            a_sr  <= bus.A;
            b_sr  <= bus.B;
            carry <= bus.C_in;
            cnt   <= '0;
        end else if (state_q == ST_RUN) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            s_sr  <= s_shift;
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s_q <= s_shift;
                c_q <= fa_c;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic a_sgn;
    logic b_sgn;
    logic ovf_q;

    // Operand sign bits captured at accept; overflow registered with the sum
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sgn <= 1'b0;
            b_sgn <= 1'b0;
            ovf_q <= 1'b0;
        end else if (accept) begin
            a_sgn <= bus.A[W-1];
            b_sgn <= bus.B[W-1];
        end else if (last) begin
            ovf_q <= (a_sgn == b_sgn) & (fa_z != a_sgn);
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.S     = s_q;
    assign bus.C_out = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (W=8 and W=1 instances).
// Overflow checks active when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;
    import serial_add_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned pcnt = 0;
    always @(posedge clk) pcnt <= pcnt + 1;

    int errors = 0;
    int checks = 0;

    serial_adder_ctrl_if #(.W(8)) bus8();
    serial_adder_ctrl_if #(.W(1)) bus1();

    serial_adder_ctrl #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder_ctrl #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [63:0] sum;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   done8 = 0;
    int   done1 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: W-bit add with carry as plain arithmetic; signed overflow
    // from the true signed result leaving the W-bit range
    function automatic exp_t model(input int w, input longint a, input longint b, input int c);
        exp_t   e;
        longint sa, sb, r;
        longint half;
        half  = longint'(1) << (w - 1);
        e.sum = 64'(a + b + c);
        sa    = (a >= half) ? a - 2 * half : a;
        sb    = (b >= half) ? b - 2 * half : b;
        r     = sa + sb + c;
        e.ovf = (r >= half) || (r < -half);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest outstanding op
    always @(negedge clk) begin
        if (!rst && bus8.done) begin
            exp_t e;
            done8++;
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done8: got done=1 expected no pending op at t=%0t", $time);
            end else begin
                e = q8.pop_front();
                check("sum8", 64'({bus8.C_out, bus8.S}), e.sum);
                check("latency8", 64'(pcnt - e.cyc), 64'd8);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf8", 64'(bus8.ovf), 64'(e.ovf));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus1.done) begin
            exp_t e;
            done1++;
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done1: got done=1 expected no pending op at t=%0t", $time);
            end else begin
                e = q1.pop_front();
                check("sum1", 64'({bus1.C_out, bus1.S}), e.sum);
                check("latency1", 64'(pcnt - e.cyc), 64'd1);
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (bus8.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout8: got ready=%b expected 1 within 100 cycles", bus8.ready);
        end
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        bus8.C_in  = c;
        e     = model(8, longint'(a), longint'(b), int'(c));
        e.cyc = pcnt + 1;
        q8.push_back(e);
        @(posedge clk);
        #1 bus8.start = 1'b0;
    endtask

    task automatic issue1(input logic a, input logic b, input logic c);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (bus1.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout1: got ready=%b expected 1 within 100 cycles", bus1.ready);
        end
        bus1.start = 1'b1;
        bus1.A     = a;
        bus1.B     = b;
        bus1.C_in  = c;
        e     = model(1, longint'(a), longint'(b), int'(c));
        e.cyc = pcnt + 1;
        q1.push_back(e);
        @(posedge clk);
        #1 bus1.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_%s: got %0d pending ops expected 0", name, q8.size() + q1.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.C_in = 1'b0;
        bus1.start = 1'b0; bus1.A = '0; bus1.B = '0; bus1.C_in = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 64'(bus8.ready), 64'd1);
        check("rst_busy",  64'(bus8.busy),  64'd0);
        check("rst_done",  64'(bus8.done),  64'd0);
        check("rst_S",     64'({bus8.C_out, bus8.S}), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf",   64'(bus8.ovf),   64'd0);
`endif

        // Basic sum
        issue8(8'h5A, 8'h3C, 1'b0);
        drain("basic");

        // Carry out, then back-to-back op accepted on the done cycle
        issue8(8'hFF, 8'h01, 1'b0);
        issue8(8'hFF, 8'hFF, 1'b1);
        drain("b2b");

        // start while busy must be ignored
        d0 = done8;
        issue8(8'h21, 8'h43, 1'b1);
        repeat (3) @(negedge clk);
        check("busy_mid", 64'(bus8.busy), 64'd1);
        check("ready_mid", 64'(bus8.ready), 64'd0);
        bus8.start = 1'b1; bus8.A = 8'hEE; bus8.B = 8'h77; bus8.C_in = 1'b1;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        drain("ignore");
        repeat (12) @(negedge clk);
        check("single_done", 64'(done8 - d0), 64'd1);

        // Reset in the middle of a run aborts it
        issue8(8'h99, 8'h66, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q8.delete();
        d0 = done8;
        @(negedge clk);
        check("abort_ready", 64'(bus8.ready), 64'd1);
        check("abort_busy",  64'(bus8.busy),  64'd0);
        check("abort_S",     64'({bus8.C_out, bus8.S}), 64'd0);
        repeat (12) @(negedge clk);
        check("abort_no_done", 64'(done8 - d0), 64'd0);
        issue8(8'hC3, 8'h5D, 1'b1);
        drain("after_abort");

`ifdef SERIAL_ADD_OVF_EN
        issue8(8'h7F, 8'h01, 1'b0);
        issue8(8'h80, 8'hFF, 1'b0);
        issue8(8'h10, 8'h20, 1'b0);
        drain("ovf");
`endif

        // Randomized ops with random gaps (gap 0 gives back-to-back)
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        drain("random");

        // W=1: every input combination
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            issue1(v[2], v[1], v[0]);
        end
        drain("w1");
        check("w1_done_count", 64'(done1), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
